// File: rtl/bit32_adder_pkg.sv
// bit32_adder_pkg: shared widths for the 32-bit adder and its 4-bit lookahead groups
package bit32_adder_pkg;
    localparam int ADD_W = 32;
    localparam int GRP_W = 4;
    localparam int N_GRP = ADD_W / GRP_W;
endpackage

// File: rtl/bit32_adder_cla4.sv
// bit32_adder_cla4: combinational 4-bit carry-lookahead group with group generate/propagate
module bit32_adder_cla4
    import bit32_adder_pkg::*;
(
    input  logic [GRP_W:1] a,
    input  logic [GRP_W:1] b,
    input  logic           ci,
    output logic [GRP_W:1] s,
    output logic           co,
    output logic           g,
    output logic           p
);
    logic [GRP_W:1] gb;
    logic [GRP_W:1] pb;
    logic [GRP_W-1:0] c;
    assign gb = a & b;
    assign pb = a ^ b;
    // c[k] is the carry into bit k+1; every term is a flat sum of products
    assign c[0] = ci;
    assign c[1] = gb[1] | (pb[1] & ci);
    assign c[2] = gb[2] | (pb[2] & gb[1]) | ((&pb[2:1]) & ci);
    assign c[3] = gb[3] | (pb[3] & gb[2]) | ((&pb[3:2]) & gb[1]) | ((&pb[3:1]) & ci);
    assign g    = gb[4] | (pb[4] & gb[3]) | ((&pb[4:3]) & gb[2]) | ((&pb[4:2]) & gb[1]);
    assign p    = &pb;
    assign co   = g | (p & ci);
    assign s    = pb ^ c;
endmodule

// File: rtl/bit32_adder.sv
// bit32_adder: registered 32-bit add with carry-in/out built from rippled 4-bit lookahead groups
module bit32_adder
    import bit32_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W:1]   a,
    input  logic [ADD_W:1]   b,
    input  logic             cin,
    output logic [ADD_W:1]   sum,
    output logic             cout
);
    logic [N_GRP:0] gc;
    logic [N_GRP:1] gg;
    logic [N_GRP:1] gp;
    logic [ADD_W:1] sum_d;
    logic [ADD_W:1] sum_q;
    logic           cout_q;
    logic           unused_gp;
    assign gc[0] = cin;
    // group g/p are reserved for a second lookahead level
    assign unused_gp = ^{gg, gp};
    for (genvar i = 1; i <= N_GRP; i++) begin : g_grp
        bit32_adder_cla4 u_cla4 (
            .a  (a[i*GRP_W -: GRP_W]),
            .b  (b[i*GRP_W -: GRP_W]),
            .ci (gc[i-1]),
            .s  (sum_d[i*GRP_W -: GRP_W]),
            .co (gc[i]),
            .g  (gg[i]),
            .p  (gp[i])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= gc[N_GRP];
        end
    end
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_bit32_adder.sv
// tb_bit32_adder: scoreboard bench comparing registered sum/cout against a 33-bit arithmetic model
module tb_bit32_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [32:1] a = '0;
    logic [32:1] b = '0;
    logic        cin = 1'b0;
    logic [32:1] sum;
    logic        cout;

    typedef struct {
        logic [32:0] exp;
        logic [31:0] x;
        logic [31:0] y;
        logic        c;
    } item_t;

    item_t exp_q[$];
    int tests = 0;
    int fails = 0;

    bit32_adder dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic c);
        return 33'(x) + 33'(y) + 33'(c);
    endfunction

    // entered at posedge+1; drives one operand set and returns at the next posedge+1
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic c, input logic [32:0] e);
        a = x;
        b = y;
        cin = c;
        exp_q.push_back('{e, x, y, c});
        @(posedge clk);
        #1;
    endtask

    task automatic rnd(input int n);
        logic [31:0] x, y;
        logic        c;
        repeat (n) begin
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? ~x : 32'($urandom);
            c = 1'($urandom_range(0, 1));
            issue(x, y, c, ref_add(x, y, c));
        end
    endtask

    task automatic check_rst(input string nm);
        tests++;
        if ({cout, sum} !== 33'h0) begin
            fails++;
            $display("FAIL %s: got cout=%b sum=%h, want cout=0 sum=00000000", nm, cout, sum);
        end
    endtask

    // monitor: a vector captured at a posedge with rst low is checked at the following negedge
    initial begin
        int  n;
        logic r;
        item_t it;
        forever begin
            @(posedge clk);
            n = exp_q.size();
            r = rst;
            @(negedge clk);
            if (!r && !rst && n > 0 && exp_q.size() > 0) begin
                it = exp_q.pop_front();
                tests++;
                if ({cout, sum} !== it.exp) begin
                    fails++;
                    $display("FAIL add a=%h b=%h cin=%b: got cout=%b sum=%h, want cout=%b sum=%h",
                             it.x, it.y, it.c, cout, sum, it.exp[32], it.exp[31:0]);
                end
            end
        end
    end

    initial begin
        #1;
        a = $urandom;
        b = $urandom;
        cin = 1'b1;
        rst = 1'b1;
        #1 check_rst("reset_immediate");
        @(negedge clk) check_rst("reset_hold0");
        @(negedge clk) check_rst("reset_hold1");
        @(posedge clk);
        #1 rst = 1'b0;
        issue(32'ha4202b00, 32'h0f01da11, 1'b1, 33'h0_b3220512);
        issue(32'h34501000, 32'h01a40011, 1'b0, 33'h0_35f41011);
        issue(32'h1110aaa0, 32'h01187100, 1'b1, 33'h0_12291ba1);
        issue(32'h0ffffaff, 32'hfffaffff, 1'b1, 33'h1_0ffafaff);
        issue(32'hffffffff, 32'h00000000, 1'b1, 33'h1_00000000);
        issue(32'hffffffff, 32'h00000000, 1'b0, 33'h0_ffffffff);
        issue(32'hffffffff, 32'hffffffff, 1'b1, 33'h1_ffffffff);
        issue(32'h00000000, 32'h00000000, 1'b0, 33'h0_00000000);
        issue(32'h0000000f, 32'h00000001, 1'b0, 33'h0_00000010);
        rnd(100);
        issue(32'hffff0000, 32'h0000ffff, 1'b1, 33'h1_00000000);
        rst = 1'b1;
        a = $urandom;
        b = $urandom;
        exp_q.delete();
        #1 check_rst("reset_mid_immediate");
        @(negedge clk) check_rst("reset_mid_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        rnd(100);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d unchecked results, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
